// File: rtl/buffer_fill_sequencer.sv
// Line-buffer fill sequencer: writes incoming pixels into four line slots,
// releases the video generator once enough lines are buffered.
module buffer_fill_sequencer #(
  parameter int LINE_WIDTH = 640,
  parameter int FILL_LINES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [23:0] in_data,
  input  logic        in_hstart,
  input  logic        in_vstart,
  input  logic        line_doubler,
  input  logic        add_line,
  output logic [11:0] wraddr,
  output logic [23:0] wrdata,
  output logic        wren,
  output logic        starttrigger,
  output logic        mode_restart,
  output logic        overflow
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN
  } state_t;

  localparam logic [9:0] LAST_COL = 10'(LINE_WIDTH - 1);
  localparam logic [1:0] FILL_N   = 2'(FILL_LINES);

  state_t      state;
  logic [1:0]  slot;
  logic [9:0]  column;
  logic [1:0]  line_cnt;
  logic        ld_q;
  logic        al_q;

  logic        mode_change;
  logic        accept;
  logic        px_write;
  logic        px_ovf;
  logic        px_done;
  logic [1:0]  nxt_slot;
  logic [9:0]  nxt_col;

  assign mode_change = (line_doubler != ld_q) | (add_line != al_q);

  // IDLE only listens for a frame start; other states take every pixel.
  assign accept = in_valid & ((state != IDLE) | in_vstart);

  always_comb begin
    nxt_slot = slot;
    nxt_col  = column;
    px_write = 1'b0;
    px_ovf   = 1'b0;
    if (accept) begin
      unique case (1'b1)
        in_vstart: begin
          nxt_slot = 2'd0;
          nxt_col  = 10'd0;
          px_write = 1'b1;
        end
        in_hstart & ~in_vstart: begin
          nxt_slot = slot + 2'd1;
          nxt_col  = 10'd0;
          px_write = 1'b1;
        end
        ~in_hstart & ~in_vstart & (column == LAST_COL): begin
          px_ovf = 1'b1;
        end
        ~in_hstart & ~in_vstart & (column != LAST_COL): begin
          nxt_col  = column + 10'd1;
          px_write = 1'b1;
        end
      endcase
    end
  end

  assign px_done = px_write & (nxt_col == LAST_COL);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      slot         <= 2'd0;
      column       <= 10'd0;
      line_cnt     <= 2'd0;
      wren         <= 1'b0;
      wraddr       <= 12'd0;
      wrdata       <= 24'd0;
      starttrigger <= 1'b0;
      mode_restart <= 1'b0;
      overflow     <= 1'b0;
      ld_q         <= line_doubler;
      al_q         <= add_line;
    end else begin
      ld_q         <= line_doubler;
      al_q         <= add_line;
      wren         <= 1'b0;
      mode_restart <= 1'b0;
      if (mode_change) begin
        state        <= IDLE;
        slot         <= 2'd0;
        column       <= 10'd0;
        line_cnt     <= 2'd0;
        starttrigger <= 1'b0;
        mode_restart <= 1'b1;
      end else begin
        if (px_write) begin
          wren   <= 1'b1;
          wraddr <= {nxt_slot, nxt_col};
          wrdata <= in_data;
          slot   <= nxt_slot;
          column <= nxt_col;
        end
        if (px_ovf) begin
          overflow <= 1'b1;
        end
        if (state == IDLE) begin
          line_cnt <= px_done ? 2'd1 : 2'd0;
        end else if (px_done && line_cnt != 2'd3) begin
          line_cnt <= line_cnt + 2'd1;
        end
        // Line count is checked a cycle after the completing write lands.
        unique case (state)
          IDLE: begin
            starttrigger <= 1'b0;
            if (px_write) begin
              state <= FILL;
            end
          end
          FILL: begin
            if (line_cnt >= FILL_N) begin
              state        <= RUN;
              starttrigger <= 1'b1;
            end
          end
          RUN: begin
            starttrigger <= 1'b1;
          end
          default: begin
            state        <= IDLE;
            starttrigger <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
